// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types and constants for the HUB75 frame loader
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PIX_WR,
        ST_PIX_GAP,
        ST_CTRL_WR,
        ST_CTRL_GAP,
        ST_DROP
    } state_t;

    localparam int          R_LSB     = 0;
    localparam int          G_LSB     = 8;
    localparam int          B_LSB     = 16;
    localparam int          CH_W      = 8;
    localparam logic [3:0]  PIX_MASK  = 4'b0111;
    localparam logic [3:0]  CTRL_MASK = 4'b1111;

    // Control register sits just past both pixel buffers (2 buffers x 4 bytes/pixel).
    function automatic logic [31:0] ctrl_offset(input int rows, input int cols);
        return 32'(8 * rows * cols);
    endfunction

endpackage

// File: rtl/hub75_xy_counter.sv
// rtl/hub75_xy_counter.sv - raster x/y position counter with end-of-frame flag
module hub75_xy_counter #(
    parameter  int ROWS = 64,
    parameter  int COLS = 64,
    localparam int XW   = $clog2(COLS),
    localparam int YW   = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clear,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic x_end;
    logic y_end;

    assign x_end = (x == XW'(COLS - 1));
    assign y_end = (y == YW'(ROWS - 1));
    assign last  = x_end && y_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hub75_frame_loader.sv
// rtl/hub75_frame_loader.sv - streams raster pixels into the back buffer of a double-buffered HUB75 driver
module hub75_frame_loader
    import hub75_pkg::*;
#(
    parameter int          ROWS     = 64,
    parameter int          COLS     = 64,
    parameter logic [31:0] BASEADDR = 32'h81000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    input  logic        s_last,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wmask,
    output logic        m_wen,
    output logic        m_ren,
    input  logic        m_ready,
    output logic        front_buffer,
    output logic        frame_done,
    output logic        err_short,
    output logic        err_long
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);

    state_t          state;
    state_t          next_state;
    logic [23:0]     pix;
    logic            pix_last;
    logic            front;
    logic            back;
    logic            xy_inc;
    logic            xy_clear;
    logic            xy_last;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [31:0]     pix_addr;
    logic [31:0]     pix_word;

    hub75_xy_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_xy (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (xy_inc),
        .clear (xy_clear),
        .x     (x),
        .y     (y),
        .last  (xy_last)
    );

    assign back         = ~front;
    assign front_buffer = front;
    assign m_ren        = 1'b0;
    assign pix_addr     = BASEADDR + (32'({back, y, x}) << 2);
    assign pix_word     = {8'h00, pix[B_LSB +: CH_W], pix[G_LSB +: CH_W], pix[R_LSB +: CH_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pix      <= '0;
            pix_last <= 1'b0;
            front    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && s_valid) begin
                pix      <= s_data;
                pix_last <= s_last;
            end
            if (state == ST_CTRL_GAP) begin
                front <= back;
            end
        end
    end

    // The gap states exist because the driver's ready lingers one cycle after completion.
    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        m_wen      = 1'b0;
        m_addr     = pix_addr;
        m_wdata    = pix_word;
        m_wmask    = PIX_MASK;
        xy_inc     = 1'b0;
        xy_clear   = 1'b0;
        frame_done = 1'b0;
        err_short  = 1'b0;
        err_long   = 1'b0;
        case (state)
            ST_IDLE: begin
                s_ready = 1'b1;
                if (s_valid) next_state = ST_PIX_WR;
            end
            ST_PIX_WR: begin
                m_wen = 1'b1;
                if (m_ready) next_state = ST_PIX_GAP;
            end
            ST_PIX_GAP: begin
                if (xy_last && pix_last) begin
                    next_state = ST_CTRL_WR;
                end else if (pix_last) begin
                    err_short  = 1'b1;
                    xy_clear   = 1'b1;
                    next_state = ST_IDLE;
                end else if (xy_last) begin
                    err_long   = 1'b1;
                    xy_clear   = 1'b1;
                    next_state = ST_DROP;
                end else begin
                    xy_inc     = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_CTRL_WR: begin
                m_wen   = 1'b1;
                m_addr  = BASEADDR + ctrl_offset(ROWS, COLS);
                m_wdata = {31'b0, back};
                m_wmask = CTRL_MASK;
                if (m_ready) next_state = ST_CTRL_GAP;
            end
            ST_CTRL_GAP: begin
                frame_done = 1'b1;
                xy_clear   = 1'b1;
                next_state = ST_IDLE;
            end
            ST_DROP: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    xy_clear   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_hub75_frame_loader.sv
// tb/tb_hub75_frame_loader.sv - self-checking bench for hub75_frame_loader
module tb_hub75_frame_loader;

    localparam int          ROWS = 4;
    localparam int          COLS = 4;
    localparam int          N    = ROWS * COLS;
    localparam logic [31:0] BASE = 32'h81000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_data = '0;
    logic        s_last = 1'b0;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    logic        m_wen;
    logic        m_ren;
    logic        m_ready = 1'b0;
    logic        front_buffer;
    logic        frame_done;
    logic        err_short;
    logic        err_long;

    hub75_frame_loader #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .BASEADDR (BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_wmask      (m_wmask),
        .m_wen        (m_wen),
        .m_ren        (m_ren),
        .m_ready      (m_ready),
        .front_buffer (front_buffer),
        .frame_done   (frame_done),
        .err_short    (err_short),
        .err_long     (err_long)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    typedef struct {
        int npix;
        int last_at;
        bit seq;
        int stall;
        int exp_wr;
        int exp_done;
        int exp_short;
        int exp_long;
        bit exp_front;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  exp_w;
    vec_t tbl[7];

    int tests = 0;
    int fails = 0;

    int m_idx = 0;
    bit m_front = 1'b0;
    bit m_drop = 1'b0;
    int m_done = 0, m_short = 0, m_long = 0;

    int wr_count = 0, done_cnt = 0, short_cnt = 0, long_cnt = 0, wr_idx = 0;
    int stall_idx = -1, stall_len = 10;
    bit rand_delay = 1'b0;
    int cnt = 0, cur_delay = 1;
    bit drop_seen = 1'b0;
    logic [31:0] cap_addr, cap_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour: one accepted beat produces the writes the driver should see.
    task automatic model_beat(input logic [23:0] d, input bit l);
        bit b;
        if (m_drop) begin
            if (l) begin
                m_drop = 1'b0;
                m_idx  = 0;
            end
            return;
        end
        b = !m_front;
        exp_q.push_back('{BASE + 32'(4 * (int'(b) * N + m_idx)), {8'h00, d}, 4'b0111});
        if (m_idx == N - 1 && l) begin
            exp_q.push_back('{BASE + 32'(8 * N), {31'b0, b}, 4'b1111});
            m_front = b;
            m_done++;
            m_idx = 0;
        end else if (l) begin
            m_short++;
            m_idx = 0;
        end else if (m_idx == N - 1) begin
            m_long++;
            m_drop = 1'b1;
            m_idx  = 0;
        end else begin
            m_idx++;
        end
    endtask

    // Driver model and write monitor: ready follows wen after cur_delay cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_ready = 1'b0;
            cnt     = 0;
        end else begin
            if (frame_done) done_cnt++;
            if (err_short)  short_cnt++;
            if (err_long)   long_cnt++;
            if (m_ready) begin
                m_ready = 1'b0;
                cnt     = 0;
            end else if (m_wen) begin
                if (cnt == 0) begin
                    cur_delay = (wr_idx == stall_idx) ? stall_len :
                                (rand_delay ? int'($urandom_range(1, 4)) : 1);
                    cap_addr  = m_addr;
                    cap_data  = m_wdata;
                end else begin
                    check("stall_addr", m_addr, cap_addr);
                    check("stall_data", m_wdata, cap_data);
                    check("stall_s_ready", {31'b0, s_ready}, 32'd0);
                end
                cnt++;
                if (cnt >= cur_delay) m_ready = 1'b1;
                if (m_ready) begin
                    wr_count++;
                    wr_idx++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: addr %h data %h, none required", m_addr, m_wdata);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("wr_addr", m_addr, exp_w.addr);
                        check("wr_data", m_wdata, exp_w.data);
                        check("wr_mask", {28'b0, m_wmask}, {28'b0, exp_w.mask});
                        check("m_ren", {31'b0, m_ren}, 32'd0);
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [23:0] d, input bit l);
        int t = 0;
        bit was_drop;
        was_drop = m_drop;
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = l;
        while (!s_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            tests++;
            fails++;
            $display("FAIL s_ready_timeout: got 0 after %0d cycles, required 1", t);
            s_valid = 1'b0;
            return;
        end
        if (was_drop && drop_seen) check("drop_s_ready_wait", 32'(t), 32'd0);
        drop_seen = was_drop;
        @(posedge clk);
        model_beat(d, l);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_at, input bit seq, input int max_gap);
        for (int i = 1; i <= n; i++) begin
            send_beat(seq ? 24'(i) : 24'($urandom), i == last_at);
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic clear_obs();
        wr_count  = 0;
        done_cnt  = 0;
        short_cnt = 0;
        long_cnt  = 0;
        wr_idx    = 0;
        m_done    = 0;
        m_short   = 0;
        m_long    = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int t;
        tbl[0] = '{16, 16, 1'b1, -1, 17, 1, 0, 0, 1'b1};
        tbl[1] = '{16, 16, 1'b1, -1, 17, 1, 0, 0, 1'b0};
        tbl[2] = '{5,  5,  1'b0, -1, 5,  0, 1, 0, 1'b0};
        tbl[3] = '{16, 16, 1'b0, -1, 17, 1, 0, 0, 1'b1};
        tbl[4] = '{20, 20, 1'b0, -1, 16, 0, 0, 1, 1'b1};
        tbl[5] = '{16, 16, 1'b0, 2,  17, 1, 0, 0, 1'b0};
        tbl[6] = '{16, 16, 1'b0, -1, 17, 1, 0, 0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_m_wen", {31'b0, m_wen}, 32'd0);
        check("rst_front", {31'b0, front_buffer}, 32'd0);
        check("rst_pulses", {29'b0, frame_done, err_short, err_long}, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_s_ready", {31'b0, s_ready}, 32'd1);

        for (int v = 0; v < 7; v++) begin
            clear_obs();
            stall_idx = tbl[v].stall;
            send_frame(tbl[v].npix, tbl[v].last_at, tbl[v].seq, 2);
            repeat (40) @(negedge clk);
            check("vec_queue_left", 32'(exp_q.size()), 32'd0);
            check("vec_writes", 32'(wr_count), 32'(tbl[v].exp_wr));
            check("vec_frame_done", 32'(done_cnt), 32'(tbl[v].exp_done));
            check("vec_err_short", 32'(short_cnt), 32'(tbl[v].exp_short));
            check("vec_err_long", 32'(long_cnt), 32'(tbl[v].exp_long));
            check("vec_front", {31'b0, front_buffer}, {31'b0, tbl[v].exp_front});
        end

        // Reset while the control write is stalled.
        clear_obs();
        stall_idx = 16;
        stall_len = 1000;
        send_frame(16, 16, 1'b0, 1);
        t = 0;
        while (!(m_wen && m_addr == BASE + 32'h80) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("ctrl_wr_reached", {31'b0, t < 300}, 32'd1);
        check("pre_rst_writes", 32'(wr_count), 32'd16);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_m_wen", {31'b0, m_wen}, 32'd0);
        check("mid_rst_front", {31'b0, front_buffer}, 32'd0);
        exp_q.delete();
        m_idx   = 0;
        m_front = 1'b0;
        m_drop  = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        stall_idx = -1;
        stall_len = 10;
        @(negedge clk);
        check("post_rst_s_ready", {31'b0, s_ready}, 32'd1);
        clear_obs();
        send_frame(16, 16, 1'b0, 1);
        repeat (40) @(negedge clk);
        check("post_rst_queue", 32'(exp_q.size()), 32'd0);
        check("post_rst_writes", 32'(wr_count), 32'd17);
        check("post_rst_front", {31'b0, front_buffer}, 32'd1);

        // Randomised frames with random lengths, gaps and driver latency.
        rand_delay = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int n;
            clear_obs();
            n = $urandom_range(1, 22);
            send_frame(n, n, 1'b0, 2);
            repeat (40) @(negedge clk);
            check("rnd_queue_left", 32'(exp_q.size()), 32'd0);
            check("rnd_frame_done", 32'(done_cnt), 32'(m_done));
            check("rnd_err_short", 32'(short_cnt), 32'(m_short));
            check("rnd_err_long", 32'(long_cnt), 32'(m_long));
            check("rnd_front", {31'b0, front_buffer}, {31'b0, m_front});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hub75_frame_loader.md
HUB75_FRAME_LOADER -- requirements
Module: hub75_frame_loader

Interface
REQ-001 SHALL have parameter ROWS, default 64, meaning panel rows; must be a power of 2.
REQ-002 SHALL have parameter COLS, default 64, meaning panel columns; must be a power of 2.
REQ-003 SHALL have parameter BASEADDR, default 32'h81000000, meaning the bus base of the HUB75 driver window.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 s_valid  input  1  pixel stream valid.
REQ-007 s_ready  output  1  pixel stream ready.
REQ-008 s_data  input  24  pixel, R[7:0], G[15:8], B[23:16], raster order (x fastest, then y).
REQ-009 s_last  input  1  qualifies the final pixel of a frame.
REQ-010 m_addr  output  32  bus byte address.
REQ-011 m_wdata  output  32  bus write data.
REQ-012 m_wmask  output  4  bus byte enables.
REQ-013 m_wen  output  1  bus write request.
REQ-014 m_ren  output  1  bus read request; constant 0.
REQ-015 m_ready  input  1  bus completion from the driver.
REQ-016 front_buffer  output  1  buffer currently selected for display.
REQ-017 frame_done  output  1  one-cycle pulse when a buffer swap completes.
REQ-018 err_short  output  1  one-cycle pulse when s_last arrives before pixel ROWS*COLS-1.
REQ-019 err_long  output  1  one-cycle pulse when pixel ROWS*COLS-1 arrives without s_last.

Function
REQ-020 States SHALL be IDLE, PIX_WR, PIX_GAP, CTRL_WR, CTRL_GAP, DROP.
REQ-021 s_ready SHALL be 1 only in IDLE and DROP; a pixel is accepted on s_valid&&s_ready.
REQ-022 Pixel accepted in IDLE SHALL be registered with its x,y counters; transition is IDLE->PIX_WR.
REQ-023 In PIX_WR: m_wen=1, m_wmask=4'b0111, m_wdata={8'h00,pixel}, m_addr=BASEADDR+4*{back,y,x}, where back=~front_buffer; all held stable until m_ready=1.
REQ-024 On m_ready=1 in PIX_WR, next state SHALL be PIX_GAP: m_wen=0 for exactly one cycle, m_ready ignored (the driver's ready is stale for one cycle).
REQ-025 PIX_GAP SHALL go to CTRL_WR if the pixel was the last and s_last=1, otherwise to IDLE; throughput is 3 cycles/pixel minimum.
REQ-026 x SHALL wrap COLS-1->0 and increment y; y SHALL wrap ROWS-1->0.
REQ-027 CTRL_WR: m_addr=BASEADDR+8*ROWS*COLS, m_wdata={31'b0,back}, m_wmask=4'b1111, m_wen=1 until m_ready=1, then CTRL_GAP.
REQ-028 CTRL_GAP (one cycle, m_wen=0): front_buffer<=back, frame_done=1, x,y<=0, next IDLE.
REQ-029 s_last on a pixel with index < ROWS*COLS-1: the pixel SHALL still be written, then err_short pulses, x,y<=0, no control write, front_buffer unchanged, next IDLE.
REQ-030 Pixel index ROWS*COLS-1 without s_last: the pixel SHALL be written, err_long pulses, next DROP.
REQ-031 DROP SHALL discard pixels with no bus activity until an accepted beat has s_last=1, then x,y<=0, next IDLE, no swap.
REQ-032 Outside PIX_WR and CTRL_WR, m_wen SHALL be 0; m_addr/m_wdata are don't-care.
REQ-033 A stalled m_ready SHALL hold the FSM indefinitely with no timeout; no pixel is lost.

Reset
REQ-034 On rst_n=0 (asynchronous): state IDLE, m_wen=0, x=y=0, front_buffer=0, frame_done=err_short=err_long=0; s_ready=1 after release.
REQ-035 Reset during PIX_WR/CTRL_WR SHALL abandon the transaction; the next frame writes buffer 1 and its control write resynchronises the driver.

Structure
REQ-036 Package hub75_pkg SHALL hold the state enum, the pixel field offsets, and the control-register offset function of ROWS, COLS.
REQ-037 One sub-module hub75_xy_counter SHALL hold x,y counters with inc, clear, and last-pixel flag outputs.

Verification (bench ROWS=4, COLS=4, driver model asserting ready 1 cycle after wen)
REQ-038 16 pixels 0x000001..0x000010, last on 16th -> 16 writes at 0x81000040..0x8100007C, then control write 0x81000080 data 1, frame_done, front_buffer=1.
REQ-039 Second identical frame -> writes to 0x81000000..0x8100003C, control data 0, front_buffer=0.
REQ-040 s_last on pixel 5 -> 5 writes, err_short pulse, no control write, next frame starts at x=0,y=0.
REQ-041 20 pixels, last on 20th -> 16 writes, err_long on 16th, 4 dropped, no swap, s_ready=1 throughout DROP.
REQ-042 m_ready delayed 10 cycles on pixel 3 -> m_addr/m_wdata stable, s_ready=0 for the whole stall.
REQ-043 rst_n low mid-CTRL_WR -> m_wen=0 immediately, front_buffer=0, next frame targets buffer 1.
